// File: rtl/seq_gen_pkg.sv
// Shared types and width helpers for the seq_gen serial pattern transmitter.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } seq_gen_state_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_gen_if.sv
// Start handshake plus serial output bundle between a pattern source and seq_gen.
interface seq_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] pat_in;
  logic [CNT_W-1:0] rep_in;
  logic             start_valid;
  logic             start_ready;
  logic             data_out;
  logic             bit_valid;
  logic             frame_start;
  logic             done;

  modport master (
    output pat_in, rep_in, start_valid,
    input  start_ready, data_out, bit_valid, frame_start, done
  );

  modport slave (
    input  pat_in, rep_in, start_valid,
    output start_ready, data_out, bit_valid, frame_start, done
  );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, repeating it
// with a fixed idle gap between repeats; every serial output is a flop.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst,
  seq_gen_if.slave  bus
);

  localparam int BIT_W = cnt_width(WIDTH);
  localparam int GAP_W = cnt_width(GAP_CYCLES + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  seq_gen_state_t   state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] pat_q;
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic             data_out_r;
  logic             bit_valid_r;
  logic             frame_start_r;
  logic             done_r;

  // Ready is combinational on rst so no start can be accepted while reset is held.
  assign bus.start_ready = (state == IDLE) && !rst;
  assign bus.data_out    = data_out_r;
  assign bus.bit_valid   = bit_valid_r;
  assign bus.frame_start = frame_start_r;
  assign bus.done        = done_r;

  // Control FSM, datapath counters and output flops, all loaded with the value
  // to be shown in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sreg          <= '0;
      pat_q         <= '0;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      rep_cnt       <= '0;
      data_out_r    <= 1'b0;
      bit_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r        <= 1'b0;
      frame_start_r <= 1'b0;
      case (state)
        IDLE: begin
          data_out_r  <= 1'b0;
          bit_valid_r <= 1'b0;
          if (bus.start_valid) begin
            pat_q         <= bus.pat_in;
            sreg          <= {bus.pat_in[WIDTH-2:0], 1'b0};
            data_out_r    <= bus.pat_in[WIDTH-1];
            bit_valid_r   <= 1'b1;
            frame_start_r <= 1'b1;
            bit_cnt       <= BIT_LAST;
            rep_cnt       <= (bus.rep_in == '0) ? CNT_W'(1) : bus.rep_in;
            state         <= SHIFT;
          end
        end

        SHIFT: begin
          if (bit_cnt != '0) begin
            data_out_r  <= sreg[WIDTH-1];
            bit_valid_r <= 1'b1;
            sreg        <= {sreg[WIDTH-2:0], 1'b0};
            bit_cnt     <= bit_cnt - BIT_W'(1);
          end else if (rep_cnt > CNT_W'(1)) begin
            rep_cnt <= rep_cnt - CNT_W'(1);
            if (GAP_CYCLES == 0) begin
              // Back-to-back repeat: the next frame's MSB follows the last bit directly.
              data_out_r    <= pat_q[WIDTH-1];
              bit_valid_r   <= 1'b1;
              frame_start_r <= 1'b1;
              sreg          <= {pat_q[WIDTH-2:0], 1'b0};
              bit_cnt       <= BIT_LAST;
            end else begin
              data_out_r  <= 1'b0;
              bit_valid_r <= 1'b0;
              sreg        <= pat_q;
              gap_cnt     <= GAP_LOAD;
              state       <= GAP;
            end
          end else begin
            data_out_r  <= 1'b0;
            bit_valid_r <= 1'b0;
            done_r      <= 1'b1;
            state       <= IDLE;
          end
        end

        GAP: begin
          if (gap_cnt != '0) begin
            data_out_r  <= 1'b0;
            bit_valid_r <= 1'b0;
            gap_cnt     <= gap_cnt - GAP_W'(1);
          end else begin
            data_out_r    <= sreg[WIDTH-1];
            bit_valid_r   <= 1'b1;
            frame_start_r <= 1'b1;
            sreg          <= {sreg[WIDTH-2:0], 1'b0};
            bit_cnt       <= BIT_LAST;
            state         <= SHIFT;
          end
        end

        default: begin
          data_out_r  <= 1'b0;
          bit_valid_r <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: two instances (gap 2 and gap 0) checked cycle by cycle
// against a queue-based model of the expected serial waveform.
module tb_seq_gen;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected per-cycle tuple: {start_ready, done, frame_start, bit_valid, data_out}
  logic [4:0] q0[$];
  logic [4:0] q1[$];

  seq_gen_if #(.WIDTH(W), .CNT_W(4)) bus0 ();
  seq_gen_if #(.WIDTH(W), .CNT_W(4)) bus1 ();

  assign bus1.pat_in      = bus0.pat_in;
  assign bus1.rep_in      = bus0.rep_in;
  assign bus1.start_valid = bus0.start_valid;

  seq_gen #(.WIDTH(W), .CNT_W(4), .GAP_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  seq_gen #(.WIDTH(W), .CNT_W(4), .GAP_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_entry(input int k, input logic [4:0] e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Whole transfer as seen on the wire: R frames of W bits MSB-first, gaps between, then done.
  task automatic add_transfer(input int k, input int gap, input logic [W-1:0] pat,
                              input logic [3:0] rep);
    int r;
    r = (rep == 4'd0) ? 1 : int'(rep);
    for (int f = 0; f < r; f++) begin
      for (int i = W - 1; i >= 0; i--)
        push_entry(k, {1'b0, 1'b0, (i == W - 1), 1'b1, pat[i]});
      if (f < r - 1)
        for (int g = 0; g < gap; g++) push_entry(k, 5'b00000);
    end
    push_entry(k, 5'b11000);
  endtask

  always @(negedge clk) begin
    logic [4:0] e0;
    logic [4:0] e1;
    if (q0.size() != 0) e0 = q0.pop_front();
    else                e0 = 5'b10000;
    if (q1.size() != 0) e1 = q1.pop_front();
    else                e1 = 5'b10000;
    if (rst) begin
      e0[4] = 1'b0;
      e1[4] = 1'b0;
    end
    check("gap2_outputs", {27'd0, bus0.start_ready, bus0.done, bus0.frame_start,
                           bus0.bit_valid, bus0.data_out}, {27'd0, e0});
    check("gap0_outputs", {27'd0, bus1.start_ready, bus1.done, bus1.frame_start,
                           bus1.bit_valid, bus1.data_out}, {27'd0, e1});
    if (rst) begin
      q0.delete();
      q1.delete();
    end else if (bus0.start_valid) begin
      if (e0[4]) add_transfer(0, 2, bus0.pat_in, bus0.rep_in);
      if (e1[4]) add_transfer(1, 0, bus1.pat_in, bus1.rep_in);
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus0.start_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", {31'd0, bus0.start_ready}, 32'd1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", q0.size() + q1.size(), 32'd0);
  endtask

  // Present a request, hold it until accepted, then scramble pat_in to prove it was latched.
  task automatic send(input logic [W-1:0] p, input logic [3:0] r, input bit hold);
    @(posedge clk);
    #1;
    bus0.pat_in      = p;
    bus0.rep_in      = r;
    bus0.start_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    if (!hold) bus0.start_valid = 1'b0;
    bus0.pat_in = ~p;
    bus0.rep_in = 4'd7;
  endtask

  initial begin
    rst              = 1'b1;
    bus0.start_valid = 1'b0;
    bus0.pat_in      = '0;
    bus0.rep_in      = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(8'hE8, 4'd1, 1'b0); wait_idle();
    send(8'hE8, 4'd3, 1'b0); wait_idle();
    send(8'hA5, 4'd0, 1'b0); wait_idle();
    send(8'h3C, 4'd2, 1'b0); wait_idle();

    // Held start_valid: second transfer taken in the done cycle with the new pattern.
    send(8'hE8, 4'd1, 1'b1);
    bus0.pat_in = 8'h0F;
    bus0.rep_in = 4'd1;
    wait_ready();
    @(posedge clk);
    #1 bus0.start_valid = 1'b0;
    wait_idle();

    // Reset during the fourth bit, then a fresh transfer.
    send(8'h96, 4'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'h5A, 4'd1, 1'b0); wait_idle();

    for (int it = 0; it < 40; it++) begin
      int n;
      send(W'($urandom), 4'($urandom_range(0, 6)), 1'b0);
      n = $urandom_range(0, 30);
      for (int c = 0; c < n; c++) begin
        @(posedge clk);
        #1;
        bus0.pat_in      = W'($urandom);
        bus0.rep_in      = 4'($urandom_range(0, 15));
        bus0.start_valid = ($urandom_range(0, 3) == 0);
        rst              = ($urandom_range(0, 40) == 0);
      end
      @(posedge clk);
      #1;
      bus0.start_valid = 1'b0;
      rst              = 1'b0;
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter: the sending end of the single-bit serial data line that `seq_detect` consumes. It accepts a WIDTH-bit pattern and a repeat count through a valid/ready handshake. It then shifts the pattern out MSB-first, one bit per `clk`, repeating it the requested number of times with a fixed idle gap between repeats. The block drives the detector's `data_in` directly in block-level and system benches, replacing hand-written stimulus.

## Interface
- `WIDTH`, default 8: pattern length in bits (range 2–32).
- `CNT_W`, default 4: repeat-count width.
- `GAP_CYCLES`, default 2: idle cycles (`data_out`=0) between repeats; 0 means back-to-back.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `pat_in`  in  WIDTH  pattern to send; bit WIDTH-1 is sent first.
- `rep_in`  in  CNT_W  number of transmissions; 0 is treated as 1.
- `start_valid`  in  1  request to start a transfer.
- `start_ready`  out  1  high only in IDLE and only while `rst`=0.
- `data_out`  out  1  serial bit, registered.
- `bit_valid`  out  1  high while `data_out` carries a pattern bit, registered.
- `frame_start`  out  1  high with the first bit of each repeat, registered.
- `done`  out  1  one-cycle pulse after the final bit of the final repeat, registered.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - `start_ready`=1.
  - On `start_valid && start_ready`, capture `pat_in` into the shift register and `max(rep_in,1)` into the repeat counter, load the bit counter with WIDTH-1, and go to SHIFT.
- SHIFT:
  - Each cycle, present the shift-register MSB on `data_out` with `bit_valid`=1, then shift left.
  - `frame_start`=1 on the bit where the bit counter equals WIDTH-1.
  - When the bit counter reaches 0 on the last bit:
    - If the remaining repeat count is >1: decrement it, reload the pattern from the captured copy (a separate `pat_q` register), then go to GAP. If GAP_CYCLES=0, go straight back to SHIFT instead.
    - Otherwise go to IDLE and pulse `done`.
- GAP:
  - `data_out`=0, `bit_valid`=0 for exactly GAP_CYCLES cycles, then SHIFT.
- `pat_in` and `rep_in` are sampled only at handshake acceptance. Later changes have no effect on a transfer in progress.
- `start_valid` while not ready is ignored; nothing is queued.
- Counters:
  - The bit counter is `$clog2(WIDTH)` bits wide.
  - The gap counter is `$clog2(GAP_CYCLES+1)` bits wide (min 1).
  - The repeat counter is CNT_W bits wide; it never wraps because 0 is mapped to 1.

## Timing
- Reset values: `data_out`=0, `bit_valid`=0, `frame_start`=0, `done`=0, state IDLE, all counters 0. `start_ready`=0 while `rst`=1.
- Reset mid-transfer: in the cycle after the `rst` edge, all outputs are at reset values and the transfer is discarded. `start_ready`=1 in the first cycle with `rst`=0.
- Handshake at edge N → first bit visible on `data_out` during cycle N+1 (latency 1).
- One transfer of R repeats spans WIDTH·R + GAP_CYCLES·(R−1) cycles of output.
- `done` is high in the cycle immediately after the final bit. `start_ready` is also 1 in that same cycle.
- Start accepted in the `done` cycle: the next first bit follows with no extra idle cycle, so `bit_valid` has a single 0 cycle between transfers.
- `data_out` is 0 whenever `bit_valid`=0.

## Structure
- Package `seq_gen_pkg` holds:
  - the state enum `seq_gen_state_t` (IDLE, SHIFT, GAP);
  - the localparam helper for counter widths.
- Single module; no sub-module.
- One shift register plus `pat_q`, and three counters (bit, gap, repeat), all in the same clocked process.
- Output flops are driven from next-state logic so every output is registered.

## Test plan
- `pat_in`=8'hE8, `rep_in`=1, start at edge 0 → `data_out`=1,1,1,0,1,0,0,0 in cycles 1–8, `frame_start` only in cycle 1, `done` in cycle 9, `start_ready`=0 in cycles 1–8.
- `pat_in`=8'hE8, `rep_in`=3, GAP_CYCLES=2 → three frames, each with `frame_start` on its first bit. Bits in cycles 1–8, 11–18 and 21–28; `bit_valid`=0 and `data_out`=0 in cycles 9–10 and 19–20; `done` in cycle 29.
- `rep_in`=0 → identical to `rep_in`=1. With GAP_CYCLES=0 and `rep_in`=2, 16 contiguous `bit_valid` cycles.
- `start_valid` held high throughout with new `pat_in`=8'h0F after acceptance → first transfer sends E8 unchanged. The second transfer is accepted in the `done` cycle and its first bit (0 from 0F) follows one cycle later.
- `rst` pulsed high for one cycle at cycle 4 of a transfer → the next cycle shows all outputs 0 and `start_ready`=1. A fresh start then sends the full new pattern from its MSB.
- Scoreboard check: drive the output into `seq_detect` with `pat_in` set to its target sequence → `sout` asserts exactly once per repeat.
